// File: rtl/issue_buffer.sv
// In-order fetch-to-issue buffer: enqueues up to WIDTH leading valid lanes per cycle and
// dispatches up to WIDTH entries oldest-first, limited by ROB/RS credits, WFI halt and flush.

package issue_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] NPC;
        logic [31:0] PC;
    } IF_ID_PACKET;

    localparam logic [31:0] WFI = 32'h1050_0073;
endpackage

module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int NW    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  IF_ID_PACKET       if_packet_in    [WIDTH],
    input  logic              flush,
    input  logic [CW-1:0]     rob_credit,
    input  logic [CW-1:0]     rs_credit,
    output logic              stall_out,
    output IF_ID_PACKET       dispatch_packet [WIDTH],
    output logic [WIDTH-1:0]  dispatch_valid,
    output logic [CW-1:0]     dispatch_count,
    output logic [NW-1:0]     count,
    output logic              halted
);

    localparam int PW = $clog2(DEPTH);

    IF_ID_PACKET   mem_q [DEPTH];
    IF_ID_PACKET   mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [NW-1:0] count_q, count_d;
    logic          halted_q, halted_d;

    logic [NW-1:0] free_slots;
    logic [CW-1:0] enq_n;
    logic [CW-1:0] deq_base;
    logic [CW-1:0] deq_n;
    logic          wfi_hit;
    logic          enq_run;
    logic          deq_stop;

    // A misbehaving ROB/RS may report more than WIDTH free slots; clamp it.
    function automatic logic [CW-1:0] sat_credit(input logic [CW-1:0] c);
        return (int'(c) > WIDTH) ? CW'(WIDTH) : c;
    endfunction

    function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [CW-1:0] sat_occupancy(input logic [NW-1:0] occ);
        return (occ > NW'(WIDTH)) ? CW'(WIDTH) : CW'(occ);
    endfunction

    // Stall looks only at registered occupancy so credits never reach fetch combinationally.
    always_comb begin
        free_slots = NW'(DEPTH) - count_q;
        stall_out  = free_slots < NW'(WIDTH);
    end

    always_comb begin
        enq_n   = '0;
        enq_run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (enq_run && if_packet_in[i].valid) begin
                enq_n = enq_n + CW'(1);
            end else begin
                enq_run = 1'b0;
            end
        end
        if (stall_out || flush || reset) begin
            enq_n = '0;
        end
    end

    always_comb begin
        deq_base = min_cw(min_cw(sat_occupancy(count_q), sat_credit(rob_credit)),
                          sat_credit(rs_credit));
        deq_n    = '0;
        wfi_hit  = 1'b0;
        deq_stop = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            dispatch_packet[i] = mem_q[head_q + PW'(i)];
            if (!deq_stop && (CW'(i) < deq_base)) begin
                deq_n = deq_n + CW'(1);
                // A WFI is the last lane released; younger lanes wait behind the halt.
                if (dispatch_packet[i].inst == WFI) begin
                    deq_stop = 1'b1;
                    wfi_hit  = 1'b1;
                end
            end
        end
        if (halted_q || flush || reset) begin
            deq_n   = '0;
            wfi_hit = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            dispatch_valid[i]        = CW'(i) < deq_n;
            dispatch_packet[i].valid = CW'(i) < deq_n;
        end
        dispatch_count = deq_n;
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) < enq_n) begin
                mem_d[tail_q + PW'(i)] = if_packet_in[i];
            end
        end
    end

    always_comb begin
        head_d   = head_q + PW'(deq_n);
        tail_d   = tail_q + PW'(enq_n);
        count_d  = count_q + NW'(enq_n) - NW'(deq_n);
        halted_d = halted_q | wfi_hit;
        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign count  = count_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer (WIDTH=2, DEPTH=8) with immediate-assertion checks.

module tb_issue_buffer;
    import issue_buffer_pkg::*;

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] ADD  = 32'h0000_0033;

    logic        clock = 1'b0;
    logic        reset;
    IF_ID_PACKET lanes [2];
    logic        flush;
    logic [1:0]  rob_credit;
    logic [1:0]  rs_credit;
    logic        stall_out;
    IF_ID_PACKET dp [2];
    logic [1:0]  dispatch_valid;
    logic [1:0]  dispatch_count;
    logic [3:0]  count;
    logic        halted;

    int total = 0;
    int bad   = 0;
    int sent;
    int rcv;
    logic will_enq;

    issue_buffer #(.WIDTH(2), .DEPTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_packet_in   (lanes),
        .flush          (flush),
        .rob_credit     (rob_credit),
        .rs_credit      (rs_credit),
        .stall_out      (stall_out),
        .dispatch_packet(dp),
        .dispatch_valid (dispatch_valid),
        .dispatch_count (dispatch_count),
        .count          (count),
        .halted         (halted)
    );

    always #5 clock = ~clock;

    function automatic IF_ID_PACKET mk(input logic [31:0] pc, input logic [31:0] inst);
        IF_ID_PACKET p;
        p.valid = 1'b1;
        p.inst  = inst;
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic put(input logic [31:0] pc0, input logic [31:0] in0,
                       input logic [31:0] pc1, input logic [31:0] in1);
        lanes[0] = mk(pc0, in0);
        lanes[1] = mk(pc1, in1);
    endtask

    task automatic clear_lanes();
        lanes[0] = '0;
        lanes[1] = '0;
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        rob_credit = 2'd2;
        rs_credit  = 2'd2;
        put(32'h0, ADDI, 32'h4, ADDI);

        // Reset held with valid lanes and credits
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_stall", 32'(stall_out), 32'd0);
            chk("rst_dvalid", 32'(dispatch_valid), 32'd0);
        end
        reset = 1'b0;
        clear_lanes();
        settle();
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_dcount", 32'(dispatch_count), 32'd0);

        // Basic flow
        put(32'h0, ADDI, 32'h4, ADDI);
        settle();
        chk("basic_c0_dcount", 32'(dispatch_count), 32'd0);
        tick();
        clear_lanes();
        settle();
        chk("basic_dcount", 32'(dispatch_count), 32'd2);
        chk("basic_pc0", dp[0].PC, 32'h0);
        chk("basic_pc1", dp[1].PC, 32'h4);
        chk("basic_dvalid", 32'(dispatch_valid), 32'h3);
        tick();
        chk("basic_count", 32'(count), 32'd0);

        // Credit limit
        rob_credit = 2'd0;
        rs_credit  = 2'd0;
        put(32'h0, ADDI, 32'h4, ADDI);
        tick();
        put(32'h8, ADDI, 32'hC, ADDI);
        tick();
        clear_lanes();
        chk("cred_fill", 32'(count), 32'd4);
        rob_credit = 2'd1;
        rs_credit  = 2'd2;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("cred_dcount", 32'(dispatch_count), 32'd1);
            chk("cred_pc", dp[0].PC, 32'(4 * k));
            tick();
        end
        chk("cred_count", 32'(count), 32'd0);

        // Fill and stall
        rob_credit = 2'd0;
        rs_credit  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            chk("fill_stall_lo", 32'(stall_out), 32'd0);
            put(32'h100 + 32'(8 * k), ADDI, 32'h104 + 32'(8 * k), ADDI);
            tick();
            chk("fill_count", 32'(count), 32'(2 * (k + 1)));
        end
        chk("fill_stall_hi", 32'(stall_out), 32'd1);
        put(32'h200, ADDI, 32'h204, ADDI);
        tick();
        chk("fill_dropped", 32'(count), 32'd8);
        clear_lanes();
        rob_credit = 2'd2;
        rs_credit  = 2'd2;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("drain_dcount", 32'(dispatch_count), 32'd2);
            chk("drain_pc0", dp[0].PC, 32'h100 + 32'(8 * k));
            chk("drain_pc1", dp[1].PC, 32'h104 + 32'(8 * k));
            tick();
        end
        chk("drain_count", 32'(count), 32'd0);

        // Halt on WFI
        put(32'h300, WFI, 32'h304, ADD);
        tick();
        clear_lanes();
        settle();
        chk("halt_dcount", 32'(dispatch_count), 32'd1);
        chk("halt_dvalid", 32'(dispatch_valid), 32'h1);
        chk("halt_pc0", dp[0].PC, 32'h300);
        chk("halt_lane1_pc", dp[1].PC, 32'h304);
        chk("halt_lane1_valid", 32'(dp[1].valid), 32'd0);
        tick();
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_hold_dcount", 32'(dispatch_count), 32'd0);
        chk("halt_hold_count", 32'(count), 32'd1);
        tick();
        chk("halt_hold2_dcount", 32'(dispatch_count), 32'd0);
        flush = 1'b1;
        settle();
        chk("halt_flush_dvalid", 32'(dispatch_valid), 32'd0);
        tick();
        flush = 1'b0;
        chk("halt_cleared", 32'(halted), 32'd0);
        chk("halt_flush_count", 32'(count), 32'd0);
        put(32'h400, ADDI, 32'h404, ADDI);
        tick();
        clear_lanes();
        settle();
        chk("resume_dcount", 32'(dispatch_count), 32'd2);
        chk("resume_pc0", dp[0].PC, 32'h400);
        tick();
        chk("resume_count", 32'(count), 32'd0);

        // Wrap with credits of 1, stopping at occupancy 5
        rob_credit = 2'd1;
        rs_credit  = 2'd1;
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (sent == 12 && count == 4'd5) break;
            if (sent < 12) put(32'h500 + 32'(4 * sent), ADDI, 32'h504 + 32'(4 * sent), ADDI);
            else clear_lanes();
            settle();
            chk("wrap_dcount", 32'(dispatch_count), (cyc == 0) ? 32'd0 : 32'd1);
            if (dispatch_count != 2'd0) begin
                chk("wrap_pc", dp[0].PC, 32'h500 + 32'(4 * rcv));
                rcv++;
            end
            will_enq = !stall_out && (sent < 12);
            tick();
            if (will_enq) sent += 2;
        end
        chk("wrap_sent", 32'(sent), 32'd12);
        chk("wrap_count5", 32'(count), 32'd5);
        chk("wrap_rcv", 32'(rcv), 32'd7);

        // Flush with lanes presented
        put(32'h600, ADDI, 32'h604, ADDI);
        flush = 1'b1;
        settle();
        chk("flush_dvalid", 32'(dispatch_valid), 32'd0);
        chk("flush_dcount", 32'(dispatch_count), 32'd0);
        tick();
        flush = 1'b0;
        clear_lanes();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_stall", 32'(stall_out), 32'd0);

        // Credits above WIDTH clamp to WIDTH
        put(32'h700, ADDI, 32'h704, ADDI);
        tick();
        clear_lanes();
        rob_credit = 2'd3;
        rs_credit  = 2'd3;
        settle();
        chk("sat_dcount", 32'(dispatch_count), 32'd2);
        chk("sat_pc1", dp[1].PC, 32'h704);
        tick();
        chk("sat_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
